// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: accepts parallel words over a valid/ready handshake,
// serializes them MSB-first into a continuous bit stream, and matches that
// stream against a run-time programmed pattern. Matches are pulsed, counted
// (saturating) and compared against a threshold that raises a sticky
// interrupt.
//
// Word transfer: a word moves when s_valid and s_ready are both high at a
// rising edge of clk. s_ready is high only in IDLE and drops for the WORD_W
// cycles of serialization, so the source must hold s_valid/s_data until it
// sees s_ready high at an edge.
//
// Match pipeline: a bit enters the history at one edge, the match decision
// on the updated history is captured in match_hit at that same edge, and
// match_pulse / match_count / thresh_irq update at the following edge.
module pattern_scan_ctrl #(
    parameter int WORD_W  = 8,
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 16,
    parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_thresh,
    input  logic               s_valid,
    input  logic [WORD_W-1:0]  s_data,
    output logic               s_ready,
    output logic               busy,
    output logic               match_pulse,
    output logic [CNT_W-1:0]   match_count,
    output logic               thresh_irq,
    input  logic               irq_clr,
    output logic               state_dbg
);

    localparam int BC_W = $clog2(WORD_W + 1);
    localparam logic [LEN_W-1:0] PAT_MAX_L = LEN_W'(PAT_MAX);
    localparam logic [BC_W-1:0]  WORD_W_L  = BC_W'(WORD_W);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    logic [WORD_W-1:0]  shreg;
    logic [BC_W-1:0]    bit_cnt;
    logic [PAT_MAX-1:0] history;
    logic [LEN_W-1:0]   fill;
    logic               match_hit;

    // Latched configuration (only written while IDLE).
    logic [PAT_MAX-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   thr_q;

    // Next-state helpers for the bit being shifted this cycle.
    logic               len_ok;
    logic [PAT_MAX-1:0] hist_nxt;
    logic [LEN_W-1:0]   fill_inc;
    logic [PAT_MAX-1:0] len_mask;
    logic               match_now;
    logic [CNT_W-1:0]   cnt_inc;
    logic               irq_set;

    assign state_dbg = (state == SHIFT);

    // Combinational match decision on the history as it will look after this shift.
    always_comb begin
        len_ok   = 1'b0;
        hist_nxt = '0;
        fill_inc = '0;
        len_mask = '0;
        match_now = 1'b0;
        cnt_inc  = '0;
        irq_set  = 1'b0;

        len_ok   = (len_q != '0) && (len_q <= PAT_MAX_L);
        hist_nxt = {history[PAT_MAX-2:0], shreg[WORD_W-1]};
        fill_inc = (fill == PAT_MAX_L) ? fill : fill + LEN_W'(1);
        for (int i = 0; i < PAT_MAX; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
        match_now = len_ok && (fill_inc >= len_q) &&
                    ((hist_nxt & len_mask) == (pat_q & len_mask));

        // Saturating increment; a saturated counter never "transitions",
        // so it cannot retrigger the interrupt.
        cnt_inc = (&match_count) ? match_count : match_count + CNT_W'(1);
        irq_set = match_hit && (cnt_inc != match_count) &&
                  (thr_q != '0) && (cnt_inc == thr_q);
    end

    // Controller FSM, serializer, matcher history, counter and interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            s_ready     <= 1'b1;
            busy        <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            history     <= '0;
            fill        <= '0;
            match_hit   <= 1'b0;
            match_pulse <= 1'b0;
            match_count <= '0;
            thresh_irq  <= 1'b0;
            pat_q       <= '0;
            len_q       <= '0;
            ovl_q       <= 1'b0;
            thr_q       <= '0;
        end else begin
            // Output stage: a config write wipes the statistics and drops
            // any match still in flight from the previous stream.
            if (state == IDLE && cfg_we) begin
                match_pulse <= 1'b0;
                match_count <= '0;
                thresh_irq  <= 1'b0;
            end else begin
                match_pulse <= match_hit;
                if (match_hit) begin
                    match_count <= cnt_inc;
                end
                if (irq_set) begin
                    thresh_irq <= 1'b1;
                end else if (irq_clr) begin
                    thresh_irq <= 1'b0;
                end
            end

            match_hit <= 1'b0;

            case (state)
                IDLE: begin
                    if (cfg_we) begin
                        pat_q   <= cfg_pattern;
                        len_q   <= cfg_len;
                        ovl_q   <= cfg_overlap;
                        thr_q   <= cfg_thresh;
                        history <= '0;
                        fill    <= '0;
                    end
                    if (s_valid) begin
                        shreg   <= s_data;
                        bit_cnt <= WORD_W_L;
                        state   <= SHIFT;
                        s_ready <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    history   <= hist_nxt;
                    shreg     <= {shreg[WORD_W-2:0], 1'b0};
                    match_hit <= match_now;
                    // Non-overlapping mode restarts the fill so the next
                    // match needs a full pattern's worth of fresh bits.
                    fill      <= (match_now && !ovl_q) ? '0 : fill_inc;
                    bit_cnt   <= bit_cnt - BC_W'(1);
                    if (bit_cnt == BC_W'(1)) begin
                        state   <= IDLE;
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: table of single-word vectors, hand-written
// multi-cycle sequences, and randomized streams checked against a
// bit-stream reference model.
module tb_pattern_scan_ctrl;

    localparam int WORD_W  = 8;
    localparam int PAT_MAX = 8;
    localparam int CNT_W   = 16;
    localparam int LEN_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk;
    logic               rst;
    logic               cfg_we;
    logic [PAT_MAX-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_thresh;
    logic               s_valid;
    logic [WORD_W-1:0]  s_data;
    logic               s_ready;
    logic               busy;
    logic               match_pulse;
    logic [CNT_W-1:0]   match_count;
    logic               thresh_irq;
    logic               irq_clr;
    logic               state_dbg;

    pattern_scan_ctrl #(
        .WORD_W(WORD_W),
        .PAT_MAX(PAT_MAX),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap),
        .cfg_thresh(cfg_thresh),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .busy(busy),
        .match_pulse(match_pulse),
        .match_count(match_count),
        .thresh_irq(thresh_irq),
        .irq_clr(irq_clr),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];   // cycle numbers where match_pulse is expected
    logic [31:0] obs_q[$];   // cycle numbers where match_pulse was seen

    always @(negedge clk) begin
        if (match_pulse === 1'b1) obs_q.push_back(32'(cyc));
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The stream is a plain list of bits; a match is "the newest len bits
    // equal the pattern", counted only once enough fresh bits were seen.
    bit          mdl_bits[$];
    int          mdl_fill;
    int          mdl_count;
    bit          mdl_irq;
    logic [7:0]  m_pat;
    int          m_len;
    bit          m_ovl;
    int          m_thr;

    function automatic void model_cfg(input logic [7:0] pat, input int len,
                                      input bit ovl, input int thr);
        m_pat = pat; m_len = len; m_ovl = ovl; m_thr = thr;
        mdl_bits.delete();
        mdl_fill  = 0;
        mdl_count = 0;
        mdl_irq   = 1'b0;
    endfunction

    function automatic void model_reset();
        model_cfg(8'h00, 0, 1'b0, 0);
        exp_q.delete();
    endfunction

    function automatic void model_bit(input bit b, input int edge_no);
        bit hit;
        mdl_bits.push_back(b);
        if (mdl_bits.size() > PAT_MAX) void'(mdl_bits.pop_front());
        if (mdl_fill < PAT_MAX) mdl_fill++;
        if (m_len >= 1 && m_len <= PAT_MAX && mdl_fill >= m_len) begin
            hit = 1'b1;
            for (int i = 0; i < m_len; i++) begin
                if (mdl_bits[mdl_bits.size() - 1 - i] != m_pat[i]) hit = 1'b0;
            end
            if (hit) begin
                exp_q.push_back(32'(edge_no + 1));
                if (mdl_count < CNT_MAX) begin
                    mdl_count++;
                    if (m_thr != 0 && mdl_count == m_thr) mdl_irq = 1'b1;
                end
                if (!m_ovl) mdl_fill = 0;
            end
        end
    endfunction

    // ---------------- driver tasks (all start and end at a negedge) ----------------
    task automatic wait_ready();
        int guard = 0;
        while (s_ready !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (s_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL s_ready_timeout: got %0b, expected 1", s_ready);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        obs_q.delete();
    endtask

    task automatic drive_cfg(input logic [7:0] pat, input logic [3:0] len,
                             input bit ovl, input logic [15:0] thr);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_thresh  = thr;
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len,
                          input bit ovl, input logic [15:0] thr);
        wait_ready();
        drive_cfg(pat, len, ovl, thr);
        cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        model_cfg(pat, int'(len), ovl, int'(thr));
    endtask

    // Returns the number of the edge that accepted the word; on return the
    // bench sits at the negedge right after that edge.
    task automatic send_word(input logic [7:0] d, input bit with_cfg, output int n);
        wait_ready();
        s_valid = 1'b1;
        s_data  = d;
        if (with_cfg) cfg_we = 1'b1;
        n = cyc + 1;
        @(negedge clk);
        s_valid = 1'b0;
        cfg_we  = 1'b0;
        if (with_cfg) model_cfg(cfg_pattern, int'(cfg_len), cfg_overlap, int'(cfg_thresh));
        for (int k = 1; k <= WORD_W; k++) model_bit(d[WORD_W - k], n + k);
    endtask

    task automatic drain_check(input string tag);
        int m;
        wait_ready();
        repeat (3) @(negedge clk);
        check({tag, "_npulse"}, obs_q.size(), exp_q.size());
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) check({tag, "_pulse_cycle"}, int'(obs_q[i]), int'(exp_q[i]));
        check({tag, "_count"}, int'(match_count), mdl_count);
        check({tag, "_irq"}, int'(thresh_irq), int'(mdl_irq));
        obs_q.delete();
        exp_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] pat;
        logic [3:0] len;
        bit         ovl;
        logic [7:0] word;
        int         exp_n;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n;
        int n2;
        rst = 1'b0; cfg_we = 1'b0; s_valid = 1'b0; s_data = '0; irq_clr = 1'b0;
        drive_cfg(8'h00, 4'd0, 1'b0, 16'd0);

        vecs[0] = '{8'h0B, 4'd4, 1'b1, 8'b10110110, 2};
        vecs[1] = '{8'h0B, 4'd4, 1'b0, 8'b10110110, 1};
        vecs[2] = '{8'hFF, 4'd0, 1'b1, 8'hFF, 0};
        vecs[3] = '{8'hFF, 4'd9, 1'b1, 8'hFF, 0};
        vecs[4] = '{8'h01, 4'd1, 1'b1, 8'hA5, 4};
        vecs[5] = '{8'h03, 4'd2, 1'b1, 8'hFF, 7};
        vecs[6] = '{8'h03, 4'd2, 1'b0, 8'hFF, 4};
        vecs[7] = '{8'hA5, 4'd8, 1'b1, 8'hA5, 1};

        @(negedge clk);
        do_reset();

        // Reset state.
        check("rst_s_ready", int'(s_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(match_count), 0);
        check("rst_irq", int'(thresh_irq), 0);
        check("rst_pulse", int'(match_pulse), 0);

        // Reset leaves matching disabled.
        send_word(8'hFF, 1'b0, n);
        check("shift_busy", int'(busy), 1);
        check("shift_s_ready", int'(s_ready), 0);
        drain_check("rst_disabled");

        // s_ready low for exactly WORD_W cycles after acceptance.
        do_cfg(8'h0B, 4'd4, 1'b1, 16'd0);
        send_word(8'b10110110, 1'b0, n);
        for (int c = 1; c < WORD_W; c++) begin
            @(negedge clk);
            check("ready_low_window", int'(s_ready), 0);
        end
        @(negedge clk);
        check("ready_back", int'(s_ready), 1);
        drain_check("b6_timing");

        // Table vectors.
        for (int i = 0; i < 8; i++) begin
            do_cfg(vecs[i].pat, vecs[i].len, vecs[i].ovl, 16'd0);
            send_word(vecs[i].word, 1'b0, n);
            wait_ready();
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d_count_table", i), int'(match_count), vecs[i].exp_n);
            drain_check($sformatf("vec%0d", i));
        end

        // cfg_we during SHIFT is ignored.
        do_cfg(8'h0B, 4'd4, 1'b1, 16'd0);
        send_word(8'b10110110, 1'b0, n);
        drive_cfg(8'h01, 4'd1, 1'b0, 16'd1);
        cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        drain_check("cfg_in_shift");

        // Config and word in the same cycle: word matched under new config.
        drive_cfg(8'h01, 4'd1, 1'b1, 16'd0);
        send_word(8'h81, 1'b1, n);
        drain_check("cfg_with_word");

        // Match spanning a word boundary.
        do_cfg(8'h0B, 4'd4, 1'b1, 16'd0);
        send_word(8'b00000010, 1'b0, n);
        send_word(8'b11000000, 1'b0, n);
        drain_check("cross_word");

        // Threshold interrupt; clear coinciding with set loses.
        do_cfg(8'h0B, 4'd4, 1'b1, 16'd3);
        send_word(8'hBB, 1'b0, n);
        send_word(8'hBB, 1'b0, n2);
        check("irq_before_thresh", int'(thresh_irq), 0);
        repeat (4) @(negedge clk);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check("irq_set_wins", int'(thresh_irq), 1);
        check("irq_count3", int'(match_count), 3);
        drain_check("thresh");
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        mdl_irq = 1'b0;
        check("irq_cleared", int'(thresh_irq), 0);

        // Reset in the middle of a word discards the rest.
        send_word(8'b10100000, 1'b0, n);
        repeat (3) @(negedge clk);
        do_reset();
        check("midrst_count", int'(match_count), 0);
        check("midrst_s_ready", int'(s_ready), 1);
        check("midrst_busy", int'(busy), 0);
        do_cfg(8'h0B, 4'd4, 1'b1, 16'd0);
        send_word(8'b10110000, 1'b0, n);
        drain_check("after_midrst");

        // Randomized streams.
        for (int r = 0; r < 12; r++) begin
            do_cfg(8'($urandom), 4'($urandom_range(0, 10)), 1'($urandom_range(0, 1)),
                   16'($urandom_range(0, 5)));
            for (int w = 0; w < 6; w++) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
                send_word(8'($urandom), 1'b0, n);
            end
            drain_check($sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
